hamming_parity_scheduler: RTL and testbench

- Builds a Hamming codeword from one data word using a single shared even-parity evaluator.
- The evaluator is time-multiplexed: one parity group per cycle.
- Sits between a data producer and the channel/storage writer of the hamming encode path.
- Uses valid/ready handshakes on input and output, so it trades throughput for area compared with a fully parallel encoder.

---
 rtl/hamming_pkg.sv | 51 +++++
 rtl/hamming_parity_scheduler_if.sv | 33 +++
 rtl/hamming_group_parity.sv | 17 +
 rtl/hamming_parity_scheduler.sv | 118 +++++++++++
 tb/tb_hamming_parity_scheduler.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_pkg
// Description : Shared types and helper functions for the time-multiplexed
//               Hamming encoder (state encoding, group masks, data scatter).
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    // Widest codeword the helper functions support; callers size-cast down.
    localparam int c_MAXW = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when 1-based position pos is a power of two (a parity slot).
    function automatic logic is_parity_pos(input int pos);
        return (pos != 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Positions (bit i = position i+1) whose index has bit p set.
    function automatic logic [c_MAXW-1:0] group_mask(input int p, input int n);
        logic [c_MAXW-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) begin
            if ((((i + 1) >> p) % 2) == 1) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Place data bits, lowest first, into the non-parity positions.
    function automatic logic [c_MAXW-1:0] scatter_data(input logic [c_MAXW-1:0] data,
                                                      input int n);
        logic [c_MAXW-1:0] r;
        int j;
        r = '0;
        j = 0;
        for (int i = 0; i < n; i++) begin
            if (!is_parity_pos(i + 1)) begin
                r[i] = data[j];
                j++;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_parity_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : hamming_parity_scheduler_if
// Description : Producer/consumer handshake bundle of the Hamming scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface hamming_parity_scheduler_if #(
    parameter int DATA_WIDTH  = 4,
    parameter int PARITY_BITS = 3
);
    localparam int CODE_WIDTH = DATA_WIDTH + PARITY_BITS;

    logic [DATA_WIDTH-1:0] in;
    logic                  in_valid;
    logic                  in_ready;
    logic [CODE_WIDTH-1:0] out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;

    // Environment side: drives data in, accepts codewords out.
    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, busy
    );

    // Scheduler side.
    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/hamming_group_parity.sv
`default_nettype none
// ============================================================================
// Module      : hamming_group_parity
// Description : Shared even-parity evaluator: XOR-reduction of a masked word.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_group_parity #(
    parameter int WIDTH = 7
) (
    input  wire logic [WIDTH-1:0] i_vec,
    input  wire logic [WIDTH-1:0] i_mask,
    output logic                  o_parity
);
    // Parity of the selected group.
    assign o_parity = ^(i_vec & i_mask);
endmodule
`default_nettype wire

// File: rtl/hamming_parity_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hamming_parity_scheduler
// Description : Builds a Hamming codeword one parity group per cycle using a
//               single shared parity evaluator, with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_parity_scheduler
    import hamming_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int PARITY_BITS = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    hamming_parity_scheduler_if.slave bus
);
    localparam int CODE_WIDTH = DATA_WIDTH + PARITY_BITS;
    localparam int CNT_W      = (PARITY_BITS > 1) ? $clog2(PARITY_BITS) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(PARITY_BITS - 1);

    generate
        if ((2 ** PARITY_BITS) < (CODE_WIDTH + 1)) begin : g_bad_cfg
            $error("PARITY_BITS too small for DATA_WIDTH");
        end
    endgenerate

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_fin;      // all groups written, publish next cycle
    logic [CODE_WIDTH-1:0] r_code;     // working codeword
    logic [CODE_WIDTH-1:0] r_out;      // published codeword
    logic                  r_out_valid;
    logic                  r_in_ready;
    logic                  r_busy;

    logic [CODE_WIDTH-1:0] w_mask;
    logic [CODE_WIDTH-1:0] w_ppos;
    logic [CODE_WIDTH-1:0] w_code_next;
    logic [CODE_WIDTH-1:0] w_scatter;
    logic                  w_par;

    // Group mask and parity slot for the group being evaluated, plus the
    // scattered image of the incoming word.
    always_comb begin
        w_mask      = CODE_WIDTH'(group_mask(int'(r_cnt), CODE_WIDTH));
        w_ppos      = CODE_WIDTH'(1) << ((32'd1 << r_cnt) - 32'd1);
        w_code_next = (r_code & ~w_ppos) | (w_par ? w_ppos : '0);
        w_scatter   = CODE_WIDTH'(scatter_data(c_MAXW'(bus.in), CODE_WIDTH));
    end

    hamming_group_parity #(
        .WIDTH (CODE_WIDTH)
    ) u_group_parity (
        .i_vec    (r_code),
        .i_mask   (w_mask),
        .o_parity (w_par)
    );

    // Sequencer: accept, evaluate one group per cycle, publish, hand off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_fin       <= 1'b0;
            r_code      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_code     <= w_scatter;
                        r_cnt      <= '0;
                        r_fin      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    if (r_fin) begin
                        r_out       <= r_code;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_code <= w_code_next;
                        if (r_cnt == c_LAST) begin
                            r_fin <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_hamming_parity_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_parity_scheduler
// Description : Self-checking bench for the time-multiplexed Hamming encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_parity_scheduler;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    hamming_parity_scheduler_if #(.DATA_WIDTH(4), .PARITY_BITS(3)) bus ();

    hamming_parity_scheduler #(
        .DATA_WIDTH  (4),
        .PARITY_BITS (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic [6:0] code;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Hamming(7,4) reference: out = {d4,d3,d2,p4,d1,p2,p1}.
    function automatic logic [6:0] ref_code(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word, check latency/in_ready/codeword, then hand off after
    // hold_cycles of backpressure. Called at posedge+1 with the DUT in IDLE.
    task automatic encode(input logic [3:0] data, input logic [6:0] exp,
                          input int hold_cycles, input logic group_chk);
        int  lat;
        logic rdy_low;
        bus.in       = data;
        bus.in_valid = 1'b1;
        tick();                             // acceptance edge T
        bus.in_valid = 1'b0;
        bus.in       = ~data;               // must not disturb the result
        rdy_low      = 1'b1;
        for (lat = 1; lat <= 10; lat++) begin
            tick();
            if (bus.out_valid) break;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) rdy_low = 1'b0;
        end
        chk("latency", lat, 4);
        chk("in_ready_low_calc", rdy_low, 1'b1);
        chk("codeword", bus.out, exp);
        if (group_chk) begin
            chk("group_p1", ^(bus.out & 7'h55), 1'b0);
            chk("group_p2", ^(bus.out & 7'h66), 1'b0);
            chk("group_p4", ^(bus.out & 7'h78), 1'b0);
        end
        for (int i = 0; i < hold_cycles; i++) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("valid_drop", bus.out_valid, 1'b0);
        chk("ready_back", bus.in_ready, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{data: 4'b1011, code: 7'b1010101};
        vecs[1] = '{data: 4'hF,    code: 7'h7F};
        vecs[2] = '{data: 4'h0,    code: 7'h00};
        vecs[3] = '{data: 4'b0110, code: 7'b0110011};
        vecs[4] = '{data: 4'b0001, code: 7'h07};
        vecs[5] = '{data: 4'b1000, code: 7'h4B};

        rst_n         = 1'b0;
        bus.in        = 4'h0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset then idle for 10 cycles.
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out", bus.out, 7'h00);
        chk("rst_busy", bus.busy, 1'b0);
        repeat (10) tick();
        chk("idle_state", {bus.in_ready, bus.out_valid, bus.busy, 1'b0, 4'h0, bus.out},
            {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 7'h00});

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            encode(vecs[v].data, vecs[v].code, 0, 1'b0);
        end

        // Backpressure: hold DONE for 6 cycles while pushing junk at the input.
        bus.in       = 4'b1011;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
        chk("bp_enter_done", bus.out_valid, 1'b1);
        begin
            logic stable;
            stable = 1'b1;
            for (int i = 0; i < 6; i++) begin
                bus.in       = 4'(i);
                bus.in_valid = i[0];
                tick();
                if (bus.out_valid !== 1'b1 || bus.out !== 7'b1010101 ||
                    bus.in_ready !== 1'b0 || bus.busy !== 1'b1) stable = 1'b0;
            end
            chk("bp_stable", stable, 1'b1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_release_valid", bus.out_valid, 1'b0);
        chk("bp_release_ready", bus.in_ready, 1'b1);
        chk("bp_release_busy", bus.busy, 1'b0);
        chk("bp_out_kept", bus.out, 7'b1010101);

        // Reset in the second CALC cycle.
        bus.in       = 4'hF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out", bus.out, 7'h00);
        chk("midrst_valid", bus.out_valid, 1'b0);
        chk("midrst_ready", bus.in_ready, 1'b1);
        chk("midrst_busy", bus.busy, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_no_valid", bus.out_valid, 1'b0);
        encode(4'b0110, 7'b0110011, 0, 1'b0);

        // Exhaustive sweep, back-to-back, random hold in DONE.
        for (int d = 0; d < 16; d++) begin
            encode(4'(d), ref_code(4'(d)), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
